// File: rtl/semaforo_n.sv
// semaforo_n: N-way round-robin traffic-light controller (green / yellow / all-red).
// Latency: luz, ativo and pend are registered; a phase change shows on luz in the same cycle as the new state.
// Backpressure: none; hold freezes the green counter. Optional SEMAFORO_SKIP_EN selects demand-driven sequencing.
module semaforo_n #(
  parameter int N_WAYS     = 2,
  parameter int CNT_W      = 8,
  parameter int T_VERDE    = 4,
  parameter int T_AMARELO  = 2,
  parameter int T_VERMELHO = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_WAYS-1:0]           req,
  input  logic                        hold,
  output logic [3*N_WAYS-1:0]         luz,
  output logic [$clog2(N_WAYS)-1:0]   ativo,
  output logic [N_WAYS-1:0]           pend
);

  localparam int AW = $clog2(N_WAYS);

  typedef enum logic [1:0] {
    VERDE    = 2'd0,
    AMARELO  = 2'd1,
    VERMELHO = 2'd2
  } estado_t;

  estado_t              state_q, state_d;
  logic [AW-1:0]        ativo_q, ativo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_WAYS-1:0]    pend_q, pend_d;
  logic [3*N_WAYS-1:0]  luz_q, luz_d;
  logic [CNT_W-1:0]     t_fim;

  // Lamp pattern for a given phase and owning way: owner shows green/yellow, everyone else red.
  function automatic logic [3*N_WAYS-1:0] lamps(estado_t st, logic [AW-1:0] way);
    logic [3*N_WAYS-1:0] l;
    l = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (st == VERDE && way == AW'(i))
        l[3*i +: 3] = 3'b001;
      else if (st == AMARELO && way == AW'(i))
        l[3*i +: 3] = 3'b010;
      else
        l[3*i +: 3] = 3'b100;
    end
    return l;
  endfunction

`ifdef SEMAFORO_SKIP_EN
  logic outros_pend;

  // First pending way searching cyclically from cur+1; keeps cur when nobody is waiting.
  function automatic logic [AW-1:0] proxima(logic [AW-1:0] cur, logic [N_WAYS-1:0] p);
    logic [AW-1:0] r;
    logic          found;
    int            idx;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k <= N_WAYS; k++) begin
      idx = (int'(cur) + k) % N_WAYS;
      if (!found && p[idx]) begin
        r     = AW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction
`endif

  // Next-state, counter, pending-request and lamp computation.
  always_comb begin
    state_d = state_q;
    ativo_d = ativo_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    luz_d   = luz_q;
    t_fim   = CNT_W'(T_VERDE - 1);
`ifdef SEMAFORO_SKIP_EN
    outros_pend = |(pend_q & ~(N_WAYS'(1) << ativo_q));
`endif

    case (state_q)
      AMARELO:  t_fim = CNT_W'(T_AMARELO - 1);
      VERMELHO: t_fim = CNT_W'(T_VERMELHO - 1);
      default:  t_fim = CNT_W'(T_VERDE - 1);
    endcase

    if (int'(ativo_q) >= N_WAYS) begin
      state_d = VERDE;
      ativo_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        VERDE: begin
          if (!hold) begin
            if (cnt_q == t_fim) begin
              cnt_d = '0;
`ifdef SEMAFORO_SKIP_EN
              // Nobody else waiting: stay green and restart the phase.
              if (outros_pend)
                state_d = AMARELO;
`else
              state_d = AMARELO;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        AMARELO: begin
          if (cnt_q == t_fim) begin
            cnt_d   = '0;
            state_d = VERMELHO;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        VERMELHO: begin
          if (cnt_q == t_fim) begin
            cnt_d   = '0;
            state_d = VERDE;
`ifdef SEMAFORO_SKIP_EN
            ativo_d = proxima(ativo_q, pend_q);
`else
            ativo_d = (ativo_q == AW'(N_WAYS - 1)) ? '0 : ativo_q + AW'(1);
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = VERDE;
          ativo_d = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // A way that will be green next cycle is served: its request is dropped (clear beats a new req).
    for (int i = 0; i < N_WAYS; i++) begin
      if (state_d == VERDE && ativo_d == AW'(i))
        pend_d[i] = 1'b0;
      else
        pend_d[i] = pend_q[i] | req[i];
    end

    // Lamps follow the next state so they change together with the state register.
    luz_d = lamps(state_d, ativo_d);
  end

  // State registers with asynchronous reset to way 0 green.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VERDE;
      ativo_q <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      luz_q   <= lamps(VERDE, '0);
    end else begin
      state_q <= state_d;
      ativo_q <= ativo_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      luz_q   <= luz_d;
    end
  end

  assign luz   = luz_q;
  assign ativo = ativo_q;
  assign pend  = pend_q;

endmodule
